pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-stage register replacing the bare enable-only stage latches between core stages.

---
 rtl/pipe_stage_reg_pkg.sv | 35 +++
 rtl/pipe_stage_reg_slot.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared definitions for the pipeline-stage register: control
//               state encoding, per-boundary payload widths and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

  // The encoding doubles as the held-beat count (EMPTY=0, BUSY=1, FULL=2).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Packed payload widths for each core stage boundary.
  localparam int unsigned ID_EX_W  = 129;
  localparam int unsigned EX_MEM_W = 104;
  localparam int unsigned MEM_WB_W = 71;

  // Field offsets inside the ID/EX payload (LSB positions).
  localparam int unsigned ID_EX_PC_LSB  = 0;
  localparam int unsigned ID_EX_RS1_LSB = 32;
  localparam int unsigned ID_EX_RS2_LSB = 64;
  localparam int unsigned ID_EX_IMM_LSB = 96;
  localparam int unsigned ID_EX_CTL_LSB = 128;

  // Occupancy reported for a given control state.
  function automatic logic [1:0] occ_of(input state_e st);
    return logic'(st == ST_BUSY) ? 2'd1 : ((st == ST_FULL) ? 2'd2 : 2'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_slot
// Description : DATA_W-wide payload register with async active-low reset,
//               synchronous clear and load enable. Holds value when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg_slot #(
  parameter int unsigned DATA_W = 129
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // Next payload: clear wins over load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (i_clr) begin
      data_d = '0;
    end else if (i_ld) begin
      data_d = i_d;
    end
  end

  // Payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_q = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with flush and optional
//               2-entry skid buffer giving fully registered back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned DATA_W       = 129,
  parameter int unsigned SKID_EN      = 1,
  parameter int unsigned CLR_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occ
);

  import pipe_stage_reg_pkg::*;

  localparam logic c_SKID = (SKID_EN != 0);
  localparam logic c_CLR  = (CLR_ON_FLUSH != 0);

  state_e            state_d;
  state_e            state_q;
  logic              w_in;
  logic              w_out;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;
  logic              w_slot_clr;
  logic [DATA_W-1:0] w_main_in;
  logic [DATA_W-1:0] w_main_q;
  logic [DATA_W-1:0] w_skid_q;

  assign w_in  = i_vld & o_rdy;
  assign w_out = o_vld & i_rdy;

  // Next-state and slot control; flush overrides every transfer.
  always_comb begin
    state_d          = state_q;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    w_slot_clr       = 1'b0;
    if (i_flush) begin
      // Beats leaving this cycle were already taken; everything else drops.
      state_d    = ST_EMPTY;
      w_slot_clr = c_CLR;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in) begin
            w_main_ld = 1'b1;
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in && w_out) begin
            w_main_ld = 1'b1;
          end else if (w_in) begin
            // Only reachable with the skid slot: without it o_rdy tracks i_rdy here.
            if (c_SKID) begin
              w_skid_ld = 1'b1;
              state_d   = ST_FULL;
            end
          end else if (w_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            state_d          = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_main_in = w_main_from_skid ? w_skid_q : i_data;

  pipe_stage_reg_slot #(
    .DATA_W (DATA_W)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_main_ld),
    .i_clr (w_slot_clr),
    .i_d   (w_main_in),
    .o_q   (w_main_q)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_stage_reg_slot #(
        .DATA_W (DATA_W)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ld  (w_skid_ld),
        .i_clr (w_slot_clr),
        .i_d   (i_data),
        .o_q   (w_skid_q)
      );
      // Ready comes straight from the state flop.
      assign o_rdy = (state_q != ST_FULL);
    end else begin : g_no_skid
      assign w_skid_q = '0;
      // Single entry: accept when empty or when the held beat leaves now.
      assign o_rdy = (state_q == ST_EMPTY) | i_rdy;
    end
  endgenerate

  assign o_vld  = (state_q != ST_EMPTY);
  assign o_data = w_main_q;
  assign o_occ  = occ_of(state_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg (skid instance) plus
//               directed checks on a no-skid, clear-on-flush instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DW = 129;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_vld, i_rdy, i_flush;
  logic [DW-1:0] i_data;
  logic          o_rdy, o_vld;
  logic [DW-1:0] o_data;
  logic [1:0]    o_occ;

  logic          ns_vld, ns_rdy, ns_flush;
  logic [DW-1:0] ns_data;
  logic          ns_o_rdy, ns_o_vld;
  logic [DW-1:0] ns_o_data;
  logic [1:0]    ns_o_occ;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int mon_pend;
  int mon_occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1), .CLR_ON_FLUSH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data),
    .i_flush(i_flush), .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data), .o_occ(o_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0), .CLR_ON_FLUSH(1)) u_ns (
    .clk(clk), .rst_n(rst_n), .i_vld(ns_vld), .o_rdy(ns_o_rdy), .i_data(ns_data),
    .i_flush(ns_flush), .o_vld(ns_o_vld), .i_rdy(ns_rdy), .o_data(ns_o_data), .o_occ(ns_o_occ)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; expected beat queued when the DUT accepts it.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    i_vld = v; i_data = d; i_rdy = r; i_flush = f;
    #1;
    if (v && o_rdy && !f) exp_q.push_back(d);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    for (int w = 0; w < 5; w++) t[w*32 +: 32] = $urandom();
    return t[DW-1:0];
  endfunction

  // Monitor: compares presented beats against the queue mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      mon_pend = (i_vld && o_rdy && !i_flush) ? 1 : 0;
      mon_occ  = exp_q.size() - mon_pend;
      chk("occ", o_occ, mon_occ);
      chk("vld", o_vld, mon_occ != 0);
      chk("rdy", o_rdy, mon_occ != 2);
      if (o_vld && mon_occ != 0) begin
        chk("data", o_data, exp_q[0]);
        if (i_rdy) void'(exp_q.pop_front());
      end
      if (i_flush) exp_q.delete();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_vld = 0; i_rdy = 0; i_flush = 0; i_data = '0;
    ns_vld = 0; ns_rdy = 0; ns_flush = 0; ns_data = '0;
    #1;
    chk("por_vld", o_vld, 0);
    chk("por_data", o_data, 0);
    chk("por_occ", o_occ, 0);
    chk("por_rdy", o_rdy, 1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Stream 1..8 with 1-cycle latency.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, DW'(k), 1'b1, 1'b0);
      chk("stream_rdy", o_rdy, 1);
      if (k > 1) begin
        chk("stream_data", o_data, DW'(k - 1));
        chk("stream_vld", o_vld, 1);
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_last", o_data, 8);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Skid fill and drain.
    cyc(1'b1, 'h11, 1'b0, 1'b0);
    cyc(1'b1, 'h22, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("skid_data", o_data, 'h11);
    chk("skid_occ", o_occ, 2);
    chk("skid_rdy", o_rdy, 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("skid_d2", o_data, 'h22);
    chk("skid_occ1", o_occ, 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("skid_occ0", o_occ, 0);

    // Flush while FULL with a beat offered.
    cyc(1'b1, 'h11, 1'b0, 1'b0);
    cyc(1'b1, 'h22, 1'b0, 1'b0);
    cyc(1'b1, 'h33, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("flush_vld", o_vld, 0);
    chk("flush_occ", o_occ, 0);
    chk("flush_rdy", o_rdy, 1);
    chk("flush_hold", o_data, 'h11);

    // Reset mid-operation from FULL.
    cyc(1'b1, 'hA1, 1'b0, 1'b0);
    cyc(1'b1, 'hA2, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_occ", o_occ, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_data", o_data, 0);
    chk("rst_occ", o_occ, 0);
    chk("rst_rdy", o_rdy, 1);
    @(negedge clk); #2 rst_n = 1'b1;

    // No-skid instance: combinational ready, clear on flush.
    @(posedge clk); #1 ns_vld = 1; ns_data = 'h44; ns_rdy = 0;
    #1 chk("ns_rdy_empty", ns_o_rdy, 1);
    @(posedge clk); #1 ns_vld = 0;
    #1;
    chk("ns_vld", ns_o_vld, 1);
    chk("ns_occ", ns_o_occ, 1);
    chk("ns_rdy_stall", ns_o_rdy, 0);
    chk("ns_data", ns_o_data, 'h44);
    ns_rdy = 1; ns_vld = 1; ns_data = 'h55;
    #1 chk("ns_rdy_go", ns_o_rdy, 1);
    @(posedge clk); #1 ns_vld = 0; ns_rdy = 0;
    #1;
    chk("ns_reload", ns_o_data, 'h55);
    chk("ns_vld2", ns_o_vld, 1);
    ns_flush = 1;
    @(posedge clk); #1 ns_flush = 0;
    #1;
    chk("ns_fl_vld", ns_o_vld, 0);
    chk("ns_fl_data", ns_o_data, 0);
    chk("ns_fl_occ", ns_o_occ, 0);
    chk("ns_fl_rdy", ns_o_rdy, 1);

    // Random handshake and flush traffic against the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      cyc(($urandom % 4) != 0, rnd_data(), ($urandom % 3) != 0, ($urandom % 32) == 0);
    end
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
